// File: rtl/arithmetic_issue.sv
// Single-slot issue stage for RV32I OP / OP-IMM with a 32-entry busy scoreboard.
// Define ARITHMETIC_ISSUE_BYPASS_EN to forward retire_data into operands in the retire cycle.
module arithmetic_issue #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instruction,
  input  logic                  instruction_valid,
  output logic                  instruction_ready,
  output logic [4:0]            rs1_addr,
  output logic [4:0]            rs2_addr,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  output logic [DATA_WIDTH-1:0] lhs,
  output logic                  lhs_valid,
  output logic [DATA_WIDTH-1:0] rhs,
  output logic                  rhs_valid,
  output logic [2:0]            operation,
  output logic                  operation_valid,
  output logic [6:0]            metadata,
  output logic                  metadata_valid,
  output logic [4:0]            rd,
  input  logic                  issue_ready,
  output logic                  issue_fire,
  input  logic                  retire_valid,
  input  logic [4:0]            retire_rd,
  input  logic [DATA_WIDTH-1:0] retire_data,
  output logic                  illegal_instruction
);

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;

  logic                  r_full;
  logic                  r_is_imm;
  logic [4:0]            r_rs1;
  logic [4:0]            r_rs2;
  logic [4:0]            r_rd;
  logic [2:0]            r_funct3;
  logic [6:0]            r_metadata;
  logic [DATA_WIDTH-1:0] r_imm;
  logic [31:0]           r_busy;
  logic                  r_illegal;

  logic                  w_is_op;
  logic                  w_is_imm;
  logic                  w_legal;
  logic                  w_is_shift;
  logic                  w_accept;
  logic                  w_active;
  logic [DATA_WIDTH-1:0] w_dec_imm;
  logic [6:0]            w_dec_meta;
  logic [4:0]            w_dec_rs2;
  logic [31:0]           w_busy_set;
  logic [31:0]           w_busy_clr;
  logic [31:0]           w_busy_nxt;
  logic                  w_byp1;
  logic                  w_byp2;
  logic [DATA_WIDTH-1:0] w_lhs_src;
  logic [DATA_WIDTH-1:0] w_rhs_src;

  assign w_is_op    = (instruction[6:0] == OPC_OP);
  assign w_is_imm   = (instruction[6:0] == OPC_OP_IMM);
  assign w_legal    = w_is_op || w_is_imm;
  assign w_is_shift = w_is_imm && ((instruction[14:12] == 3'd1) || (instruction[14:12] == 3'd5));

  // Decode immediate, metadata and rs2 of the incoming word
  always_comb begin
    w_dec_imm  = '0;
    w_dec_meta = 7'd0;
    w_dec_rs2  = 5'd0;
    if (w_is_shift) begin
      w_dec_imm  = {{(DATA_WIDTH-5){1'b0}}, instruction[24:20]};
      w_dec_meta = instruction[31:25];
    end else if (w_is_imm) begin
      w_dec_imm  = {{(DATA_WIDTH-12){instruction[31]}}, instruction[31:20]};
    end else begin
      w_dec_meta = instruction[31:25];
      w_dec_rs2  = instruction[24:20];
    end
  end

`ifdef ARITHMETIC_ISSUE_BYPASS_EN
  assign w_byp1    = retire_valid && (retire_rd == r_rs1) && (r_rs1 != 5'd0);
  assign w_byp2    = retire_valid && !r_is_imm && (retire_rd == r_rs2) && (r_rs2 != 5'd0);
  assign w_lhs_src = w_byp1 ? retire_data : rs1_data;
  assign w_rhs_src = w_byp2 ? retire_data : rs2_data;
`else
  logic w_unused_retire_data;
  assign w_unused_retire_data = ^retire_data;
  assign w_byp1    = 1'b0;
  assign w_byp2    = 1'b0;
  assign w_lhs_src = rs1_data;
  assign w_rhs_src = rs2_data;
`endif

  // Reset forces every qualifier low even while the slot register still holds state
  assign w_active          = r_full && !reset;
  assign lhs_valid         = w_active && (!r_busy[r_rs1] || w_byp1);
  assign rhs_valid         = w_active && (r_is_imm || !r_busy[r_rs2] || w_byp2);
  assign operation_valid   = w_active;
  assign metadata_valid    = w_active;
  assign issue_fire        = lhs_valid && rhs_valid && !r_busy[r_rd] && issue_ready;
  assign instruction_ready = !reset && (!r_full || issue_fire);
  assign w_accept          = instruction_valid && instruction_ready;

  assign lhs                 = w_active ? w_lhs_src : '0;
  assign rhs                 = !w_active ? '0 : (r_is_imm ? r_imm : w_rhs_src);
  assign rs1_addr            = r_rs1;
  assign rs2_addr            = r_rs2;
  assign rd                  = r_rd;
  assign operation           = r_funct3;
  assign metadata            = r_metadata;
  assign illegal_instruction = r_illegal && !reset;

  // Set is applied after clear so a same-cycle issue to a retiring register keeps it busy
  assign w_busy_clr = retire_valid ? (32'd1 << retire_rd) : 32'd0;
  assign w_busy_set = issue_fire ? (32'd1 << r_rd) : 32'd0;
  assign w_busy_nxt = ((r_busy & ~w_busy_clr) | w_busy_set) & 32'hFFFF_FFFE;

  // Slot, scoreboard and illegal-pulse state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_full     <= 1'b0;
      r_is_imm   <= 1'b0;
      r_rs1      <= 5'd0;
      r_rs2      <= 5'd0;
      r_rd       <= 5'd0;
      r_funct3   <= 3'd0;
      r_metadata <= 7'd0;
      r_imm      <= '0;
      r_busy     <= 32'd0;
      r_illegal  <= 1'b0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_illegal <= w_accept && !w_legal;
      if (w_accept && w_legal) begin
        r_full     <= 1'b1;
        r_is_imm   <= w_is_imm;
        r_rs1      <= instruction[19:15];
        r_rs2      <= w_dec_rs2;
        r_rd       <= instruction[11:7];
        r_funct3   <= instruction[14:12];
        r_metadata <= w_dec_meta;
        r_imm      <= w_dec_imm;
      end else if (issue_fire) begin
        r_full <= 1'b0;
      end else begin
        r_full <= r_full;
      end
    end
  end

endmodule

// File: tb/tb_arithmetic_issue.sv
// Directed + randomized bench for arithmetic_issue with a behavioural slot/scoreboard model.
module tb_arithmetic_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        instruction_valid;
  logic        instruction_ready;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] lhs, rhs;
  logic        lhs_valid, rhs_valid;
  logic [2:0]  operation;
  logic        operation_valid;
  logic [6:0]  metadata;
  logic        metadata_valid;
  logic [4:0]  rd;
  logic        issue_ready;
  logic        issue_fire;
  logic        retire_valid;
  logic [4:0]  retire_rd;
  logic [31:0] retire_data;
  logic        illegal_instruction;

  always #5 clk = ~clk;

  arithmetic_issue dut (
    .clk(clk), .reset(reset),
    .instruction(instruction), .instruction_valid(instruction_valid),
    .instruction_ready(instruction_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .lhs(lhs), .lhs_valid(lhs_valid), .rhs(rhs), .rhs_valid(rhs_valid),
    .operation(operation), .operation_valid(operation_valid),
    .metadata(metadata), .metadata_valid(metadata_valid),
    .rd(rd), .issue_ready(issue_ready), .issue_fire(issue_fire),
    .retire_valid(retire_valid), .retire_rd(retire_rd), .retire_data(retire_data),
    .illegal_instruction(illegal_instruction)
  );

  // Register file seen by the DUT
  logic [31:0] regs [32];
  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];

`ifdef ARITHMETIC_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit          m_full;
  bit          m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [2:0]  m_f3;
  logic [6:0]  m_meta;
  logic [31:0] m_rhs_imm;
  bit          m_busy [32];
  bit          m_illegal;
  bit          e_fire, e_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic evaluate();
    bit b1, b2, lv, rv;
    logic [31:0] el, er;
    #1;
    if (reset) begin
      e_fire = 1'b0;
      e_ready = 1'b0;
      chk("rst_lhs_valid", lhs_valid, 0);
      chk("rst_rhs_valid", rhs_valid, 0);
      chk("rst_op_valid", operation_valid, 0);
      chk("rst_meta_valid", metadata_valid, 0);
      chk("rst_fire", issue_fire, 0);
      chk("rst_illegal", illegal_instruction, 0);
      return;
    end
    b1 = BYP && retire_valid && (retire_rd == m_rs1) && (m_rs1 != 0);
    b2 = BYP && !m_imm && retire_valid && (retire_rd == m_rs2) && (m_rs2 != 0);
    lv = m_full && (!m_busy[m_rs1] || b1);
    rv = m_full && (m_imm || !m_busy[m_rs2] || b2);
    e_fire  = lv && rv && !m_busy[m_rd] && issue_ready;
    e_ready = !m_full || e_fire;
    el = !m_full ? 32'd0 : (b1 ? retire_data : regs[m_rs1]);
    er = !m_full ? 32'd0 : (m_imm ? m_rhs_imm : (b2 ? retire_data : regs[m_rs2]));
    chk("ready", instruction_ready, e_ready);
    chk("fire", issue_fire, e_fire);
    chk("lhs_valid", lhs_valid, lv);
    chk("rhs_valid", rhs_valid, rv);
    chk("op_valid", operation_valid, m_full);
    chk("meta_valid", metadata_valid, m_full);
    chk("illegal", illegal_instruction, m_illegal);
    chk("lhs", lhs, el);
    chk("rhs", rhs, er);
    if (m_full) begin
      chk("operation", operation, m_f3);
      chk("metadata", metadata, m_meta);
      chk("rd", rd, m_rd);
      chk("rs1_addr", rs1_addr, m_rs1);
      chk("rs2_addr", rs2_addr, m_rs2);
    end
  endtask

  task automatic advance();
    bit load, ill;
    logic [31:0] ins;
    @(posedge clk);
    if (reset) begin
      m_full = 1'b0;
      m_illegal = 1'b0;
      foreach (m_busy[k]) m_busy[k] = 1'b0;
    end else begin
      ins  = instruction;
      load = 1'b0;
      ill  = 1'b0;
      if (instruction_valid && e_ready) begin
        if (ins[6:0] == 7'h33 || ins[6:0] == 7'h13) load = 1'b1;
        else ill = 1'b1;
      end
      if (retire_valid && retire_rd != 0) m_busy[retire_rd] = 1'b0;
      if (e_fire && m_rd != 0) m_busy[m_rd] = 1'b1;
      if (retire_valid && retire_rd != 0) regs[retire_rd] = retire_data;
      if (load) begin
        m_full = 1'b1;
        m_imm  = (ins[6:0] == 7'h13);
        m_rd   = ins[11:7];
        m_f3   = ins[14:12];
        m_rs1  = ins[19:15];
        m_rs2  = m_imm ? 5'd0 : ins[24:20];
        if (!m_imm) begin
          m_meta = ins[31:25];
          m_rhs_imm = 32'd0;
        end else if (m_f3 == 3'd1 || m_f3 == 3'd5) begin
          m_meta = ins[31:25];
          m_rhs_imm = 32'(ins[24:20]);
        end else begin
          m_meta = 7'd0;
          m_rhs_imm = 32'($signed(ins[31:20]));
        end
      end else if (e_fire) begin
        m_full = 1'b0;
      end
      m_illegal = ill;
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    evaluate();
    advance();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] r_d, r_s1, r_s2;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [11:0] imm;
    int kind;
    kind = $urandom_range(0, 9);
    r_d  = 5'($urandom_range(0, 7));
    r_s1 = 5'($urandom_range(0, 7));
    r_s2 = 5'($urandom_range(0, 7));
    f3   = 3'($urandom_range(0, 7));
    f7   = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    imm  = 12'($urandom);
    if (kind == 0) begin
      case ($urandom_range(0, 3))
        0: return {25'($urandom), 7'h37};
        1: return {25'($urandom), 7'h03};
        2: return {25'($urandom), 7'h63};
        default: return {25'($urandom), 7'h6F};
      endcase
    end else if (kind < 5) begin
      return {f7, r_s2, r_s1, f3, r_d, 7'h33};
    end else begin
      return {imm, r_s1, f3, r_d, 7'h13};
    end
  endfunction

  initial begin
    reset = 1'b1;
    instruction = 32'd0;
    instruction_valid = 1'b0;
    issue_ready = 1'b0;
    retire_valid = 1'b0;
    retire_rd = 5'd0;
    retire_data = 32'd0;
    regs[0] = 32'd0;
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    m_full = 1'b0; m_imm = 1'b0; m_rs1 = 5'd0; m_rs2 = 5'd0; m_rd = 5'd0;
    m_f3 = 3'd0; m_meta = 7'd0; m_rhs_imm = 32'd0; m_illegal = 1'b0;
    foreach (m_busy[k]) m_busy[k] = 1'b0;
    @(negedge clk);
    instruction_valid = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    instruction_valid = 1'b0;
    evaluate();
    chk("first_ready", instruction_ready, 1);
    advance();

    // add x3,x1,x2
    instruction = 32'h002081B3; instruction_valid = 1'b1; issue_ready = 1'b1;
    cyc();
    instruction = 32'hFFF18213;
    evaluate();
    chk("add_lhs", lhs, 32'd5);
    chk("add_rhs", rhs, 32'd7);
    chk("add_op", operation, 0);
    chk("add_meta", metadata, 0);
    chk("add_rd", rd, 3);
    chk("add_fire", issue_fire, 1);
    advance();
    // addi x4,x3,-1 waits on x3
    instruction_valid = 1'b0;
    evaluate();
    chk("addi_stall_lv", lhs_valid, 0);
    chk("addi_stall_fire", issue_fire, 0);
    advance();
    retire_valid = 1'b1; retire_rd = 5'd3; retire_data = 32'd12;
    evaluate();
`ifdef ARITHMETIC_ISSUE_BYPASS_EN
    chk("addi_byp_fire", issue_fire, 1);
    chk("addi_byp_lhs", lhs, 32'd12);
    chk("addi_byp_rhs", rhs, 32'hFFFF_FFFF);
    advance();
    retire_valid = 1'b0;
`else
    chk("addi_retire_fire", issue_fire, 0);
    advance();
    retire_valid = 1'b0;
    evaluate();
    chk("addi_fire", issue_fire, 1);
    chk("addi_lhs", lhs, 32'd12);
    chk("addi_rhs", rhs, 32'hFFFF_FFFF);
    advance();
`endif

    // srai x5,x1,3 while x4 retires
    instruction = 32'h4030D293; instruction_valid = 1'b1;
    retire_valid = 1'b1; retire_rd = 5'd4; retire_data = $urandom;
    cyc();
    instruction_valid = 1'b0; retire_valid = 1'b0;
    evaluate();
    chk("srai_rhs", rhs, 32'd3);
    chk("srai_meta", metadata, 7'h20);
    chk("srai_op", operation, 5);
    chk("srai_rd", rd, 5);
    chk("srai_fire", issue_fire, 1);
    advance();

    // lui is dropped as illegal
    instruction = 32'h000012B7; instruction_valid = 1'b1;
    retire_valid = 1'b1; retire_rd = 5'd5; retire_data = $urandom;
    cyc();
    instruction_valid = 1'b0; retire_valid = 1'b0;
    evaluate();
    chk("lui_illegal", illegal_instruction, 1);
    chk("lui_fire", issue_fire, 0);
    chk("lui_opv", operation_valid, 0);
    advance();
    evaluate();
    chk("lui_pulse_end", illegal_instruction, 0);
    advance();

    // add x6,x1,x2 stalled by issue_ready
    instruction = 32'h00208333; instruction_valid = 1'b1; issue_ready = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      evaluate();
      chk("stall_ready", instruction_ready, 0);
      chk("stall_fire", issue_fire, 0);
      chk("stall_rd", rd, 6);
      chk("stall_lhs", lhs, 32'd5);
      advance();
    end
    issue_ready = 1'b1; instruction_valid = 1'b0;
    evaluate();
    chk("stall_release_fire", issue_fire, 1);
    advance();

    // Reset with busy[3] set and a stalled slot
    retire_valid = 1'b1; retire_rd = 5'd6; retire_data = $urandom;
    instruction = 32'h002081B3; instruction_valid = 1'b1;
    cyc();
    retire_valid = 1'b0;
    instruction = 32'hFFF18213;
    cyc();
    instruction_valid = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    instruction_valid = 1'b1;
    cyc();
    instruction_valid = 1'b0;
    evaluate();
    chk("post_reset_fire", issue_fire, 1);
    advance();

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      int r;
      reset = ($urandom_range(0, 99) == 0);
      instruction = rand_instr();
      instruction_valid = ($urandom_range(0, 3) != 0);
      issue_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(1, 7);
      retire_rd = 5'(r);
      retire_valid = m_busy[r] ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      retire_data = $urandom;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arithmetic_issue.md
ARITHMETIC_ISSUE -- requirements
Module: arithmetic_issue

Interface
REQ-001 DATA_WIDTH, 32, operand/register width.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instruction  input  32  RV32I instruction word.
REQ-005 instruction_valid  input  1  instruction present.
REQ-006 instruction_ready  output  1  slot can accept this cycle.
REQ-007 rs1_addr  output  5  register-file read address A.
REQ-008 rs2_addr  output  5  register-file read address B.
REQ-009 rs1_data  input  DATA_WIDTH  combinational read data A.
REQ-010 rs2_data  input  DATA_WIDTH  combinational read data B.
REQ-011 lhs  output  DATA_WIDTH  operand to arithmetic unit.
REQ-012 lhs_valid  output  1  lhs hazard-free.
REQ-013 rhs  output  DATA_WIDTH  rs2 value or decoded immediate.
REQ-014 rhs_valid  output  1  rhs hazard-free.
REQ-015 operation  output  3  funct3 (instruction bits 14:12).
REQ-016 operation_valid  output  1  operation meaningful.
REQ-017 metadata  output  7  funct7, imm[11:5] for immediate shifts, else zero.
REQ-018 metadata_valid  output  1  metadata meaningful.
REQ-019 rd  output  5  destination register of slot instruction.
REQ-020 issue_ready  input  1  downstream accepts issue.
REQ-021 issue_fire  output  1  instruction issued this cycle.
REQ-022 retire_valid  input  1  a result is written back this cycle.
REQ-023 retire_rd  input  5  register written by retire.
REQ-024 retire_data  input  DATA_WIDTH  value written by retire.
REQ-025 illegal_instruction  output  1  one-cycle pulse, unsupported opcode dropped.

Function
REQ-026 One-entry slot SHALL load on instruction_valid && instruction_ready with opcode 0x33 (OP) or 0x13 (OP-IMM); instruction_ready = !slot_full || issue_fire.
REQ-027 Other opcodes SHALL be accepted and discarded, slot unchanged, illegal_instruction = 1 for exactly the following cycle.
REQ-028 OP: rhs = rs2_data, metadata = instr[31:25]; OP-IMM: rhs = sign-extended instr[31:20], metadata = 0, rs2_addr = 0.
REQ-029 OP-IMM funct3 1/5 (shifts): rhs = zero-extended instr[24:20], metadata = instr[31:25]; funct7 legality is NOT checked here.
REQ-030 Scoreboard: 32 busy bits, bit 0 hardwired 0; lhs_valid = slot_full && !busy[rs1]; rhs_valid = slot_full && (OP-IMM || !busy[rs2]); operation_valid = metadata_valid = slot_full.
REQ-031 issue_fire = lhs_valid && rhs_valid && !busy[rd] && issue_ready (combinational); rd != 0 sets busy[rd] at that edge.
REQ-032 retire_valid clears busy[retire_rd] at the edge; set and clear of the same register in one cycle: set wins.
REQ-033 Latency: instruction accepted at edge N SHALL allow issue_fire in cycle N+1; back-to-back independent instructions issue one per cycle.
REQ-034 Slot stalled (no fire) SHALL hold all fields; lhs/rhs re-read each cycle; lhs = rhs = 0 while slot empty.

Reset
REQ-035 reset high SHALL empty the slot, clear all busy bits, drive every valid, issue_fire and illegal_instruction to 0, and ignore instruction_valid; instruction_ready = 1 from the first cycle after reset.
REQ-036 Reset mid-stall SHALL drop the held instruction without issue.

Configuration
REQ-037 ARITHMETIC_ISSUE_BYPASS_EN defined: retire_valid with retire_rd == rs1 (nonzero) SHALL force lhs = retire_data, lhs_valid = 1 same cycle; same for rs2/rhs.
REQ-038 ARITHMETIC_ISSUE_BYPASS_EN undefined: retire_data unused; operand valid rises the cycle after retire.

Verification
REQ-039 0x002081B3 (add x3,x1,x2), x1=5, x2=7, issue_ready=1 -> next cycle lhs=5, rhs=7, operation=0, metadata=0, rd=3, issue_fire=1, busy[3] set.
REQ-040 0xFFF18213 (addi x4,x3,-1) after REQ-039 -> lhs_valid=0 until retire rd=3, data 12; no bypass: fires cycle after; bypass: fires same cycle, lhs=12, rhs=0xFFFFFFFF.
REQ-041 0x4030D293 (srai x5,x1,3) -> rhs=3, metadata=0x20, operation=5, rd=5.
REQ-042 0x000012B7 (lui) -> accepted, illegal_instruction=1 one cycle, no issue_fire, slot still empty.
REQ-043 Slot full, issue_ready=0 for 3 cycles -> instruction_ready=0, outputs stable, busy unchanged; issue_ready=1 -> fire.
REQ-044 reset with busy[3] set and slot full -> valids 0, busy clear; then addi with rs1=x3 issues without any retire.
